// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: per-stage valid/allow_in handshake chain, inter-stage
// bus latches, global cancel, partial flush and retire/stall counters.
//
// Ports:
//   clk, resetn   clock; synchronous active-low reset
//   stage_over    bit j: stage j finished its current work
//   stage_bus_in  slice j: stage j's outgoing bus toward stage j+1
//   cancel        kill stages 1..STAGES-1
//   flush_req     partial flush request from stage flush_idx
//   flush_idx     redirecting stage k (1..STAGES-1, else ignored)
//   valid         per-stage valid
//   allow_in      per-stage accept (combinational)
//   stage_bus_r   slice j-1: registered bus feeding stage j
//   retire_cnt    completed last-stage cycles (wraps)
//   stall_cnt     fetch-blocked cycles (wraps)
module pipe_stage_ctrl #(
  parameter int STAGES = 5,
  parameter int BUS_W  = 182,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [STAGES-1:0]           stage_over,
  input  logic [STAGES*BUS_W-1:0]     stage_bus_in,
  input  logic                        cancel,
  input  logic                        flush_req,
  input  logic [IDX_W-1:0]            flush_idx,
  output logic [STAGES-1:0]           valid,
  output logic [STAGES-1:0]           allow_in,
  output logic [(STAGES-1)*BUS_W-1:0] stage_bus_r,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int L = STAGES - 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(L);
  localparam logic [BUS_W-1:0] PC_MASK =
    {BUS_W{1'b1}} >> (BUS_W - PC_W);

  logic [L:0]       valid_q;
  logic [L:0]       valid_d;
  logic [BUS_W-1:0] bus_q [1:L];
  logic [BUS_W-1:0] bus_d [1:L];
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] retire_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  logic       fl;
  logic [L:1] kill;
  logic [L:1] pin;
  logic [L:1] adv;
  logic       retire_inc;
  logic       stall_inc;

  // writeback never forwards its bus anywhere
  logic unused_bus;
  assign unused_bus = ^stage_bus_in[STAGES*BUS_W-1 -: BUS_W];

  // cancel outranks a flush; out-of-range indices are dropped
  assign fl = flush_req & ~cancel
            & (flush_idx != '0)
            & (flush_idx <= LAST);

  // back-pressure ripples from writeback toward fetch
  always_comb begin
    logic [L:0] a;
    a    = '0;
    a[L] = ~valid_q[L] | stage_over[L];
    for (int j = L - 1; j >= 1; j--) begin
      a[j] = ~valid_q[j]
           | (stage_over[j] & a[j+1]);
    end
    a[0] = (stage_over[0] & a[1])
         | cancel | fl;
    allow_in = a;
  end

  // pin: redirecting stage itself; it stays until it can leave
  always_comb begin
    kill = '0;
    pin  = '0;
    adv  = '0;
    for (int j = 1; j <= L; j++) begin
      pin[j]  = fl & (IDX_W'(j) == flush_idx);
      kill[j] = cancel
              | (fl & (IDX_W'(j) < flush_idx))
              | (pin[j] & allow_in[j]);
      adv[j]  = valid_q[j-1] & stage_over[j-1]
              & allow_in[j];
    end
  end

  // a pinned stage that is not killed has allow_in low, so it holds
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = 1'b1;
    for (int j = 1; j <= L; j++) begin
      if (kill[j]) begin
        valid_d[j] = 1'b0;
      end else if (allow_in[j]) begin
        valid_d[j] = valid_q[j-1]
                   & stage_over[j-1];
      end
    end
  end

  // killed latches keep only the PC for the debug view
  always_comb begin
    for (int j = 1; j <= L; j++) begin
      bus_d[j] = bus_q[j];
      if (kill[j]) begin
        bus_d[j] = stage_bus_in[(j-1)*BUS_W +: BUS_W]
                 & PC_MASK;
      end else if (adv[j]) begin
        bus_d[j] = stage_bus_in[(j-1)*BUS_W +: BUS_W];
      end
    end
  end

  assign retire_inc = valid_q[L] & stage_over[L];
  assign stall_inc  = valid_q[0] & stage_over[0]
                    & ~allow_in[1]
                    & ~cancel & ~fl;

  always_comb begin
    retire_d = retire_q + CNT_W'(retire_inc);
    stall_d  = stall_q + CNT_W'(stall_inc);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      for (int j = 1; j <= L; j++) begin
        bus_q[j] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
      for (int j = 1; j <= L; j++) begin
        bus_q[j] <= bus_d[j];
      end
    end
  end

  always_comb begin
    stage_bus_r = '0;
    for (int j = 1; j <= L; j++) begin
      stage_bus_r[(j-1)*BUS_W +: BUS_W] = bus_q[j];
    end
  end

  assign valid      = valid_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed stimulus for pipe_stage_ctrl with a
// behavioural occupancy model compared every cycle plus literal pins.
module tb_pipe_stage_ctrl;
  localparam int S  = 5;
  localparam int BW = 48;
  localparam int PW = 32;
  localparam int CW = 4;
  localparam int IW = 3;
  localparam logic [BW-1:0] PCM = {{(BW-PW){1'b0}}, {PW{1'b1}}};

  logic                clk = 1'b0;
  logic                resetn;
  logic [S-1:0]        stage_over;
  logic [S*BW-1:0]     bin;
  logic                cancel;
  logic                flush_req;
  logic [IW-1:0]       flush_idx;
  logic [S-1:0]        valid;
  logic [S-1:0]        allow_in;
  logic [(S-1)*BW-1:0] sbr;
  logic [CW-1:0]       retire_cnt;
  logic [CW-1:0]       stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] fpc;
  logic [31:0] exp_rpc;
  bit          rtrack;

  pipe_stage_ctrl #(
    .STAGES(S), .BUS_W(BW), .PC_W(PW),
    .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .stage_over(stage_over), .stage_bus_in(bin),
    .cancel(cancel), .flush_req(flush_req),
    .flush_idx(flush_idx), .valid(valid),
    .allow_in(allow_in), .stage_bus_r(sbr),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // fetch PC source and pass-through stages that tag their bus
  always @(posedge clk) begin
    if (!resetn) fpc <= 32'h100;
    else if (valid[0] && stage_over[0] && allow_in[1])
      fpc <= fpc + 32'd4;
  end

  always_comb begin
    bin = '0;
    bin[0 +: BW] = {16'hA5A5, fpc};
    for (int j = 1; j < S; j++)
      bin[j*BW +: BW] = sbr[(j-1)*BW +: BW] ^ {16'(j), 32'h0};
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [S-1:0]  mv;
  logic [BW-1:0] mb [S];
  logic [CW-1:0] mret;
  logic [CW-1:0] mstall;
  bit            mready = 1'b0;

  function automatic bit m_fl();
    return flush_req && !cancel && flush_idx >= 1
        && int'(flush_idx) <= S - 1;
  endfunction

  // a slot frees up when every occupied stage from it up to the
  // first empty one (or the end of the pipe) has finished
  function automatic bit m_drains(int j);
    for (int i = j; i < S; i++) begin
      if (!mv[i]) return 1'b1;
      if (!stage_over[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [S-1:0] m_allow();
    logic [S-1:0] a;
    a = '0;
    for (int j = 1; j < S; j++) a[j] = m_drains(j);
    a[0] = (stage_over[0] && m_drains(1)) || cancel || m_fl();
    return a;
  endfunction

  always @(posedge clk) begin : model
    logic [S-1:0]  a;
    logic [S-1:0]  nv;
    logic [BW-1:0] nb [S];
    logic [BW-1:0] src;
    bit f;
    int k;
    if (!resetn) begin
      mv <= '0;
      for (int i = 0; i < S; i++) mb[i] <= '0;
      mret   <= '0;
      mstall <= '0;
      mready <= 1'b1;
    end else begin
      a  = m_allow();
      f  = m_fl();
      k  = int'(flush_idx);
      nv = mv;
      nb = mb;
      nv[0] = 1'b1;
      for (int j = 1; j < S; j++) begin
        src = bin[(j-1)*BW +: BW];
        if (cancel || (f && j < k) || (f && j == k && a[j])) begin
          nv[j] = 1'b0;
          nb[j] = src & PCM;
        end else if (f && j == k) begin
          nv[j] = mv[j];
        end else if (a[j]) begin
          nv[j] = mv[j-1] && stage_over[j-1];
          if (nv[j]) nb[j] = src;
        end
      end
      if (mv[S-1] && stage_over[S-1]) mret <= mret + 1'b1;
      if (mv[0] && stage_over[0] && !a[1] && !cancel && !f)
        mstall <= mstall + 1'b1;
      mv <= nv;
      mb <= nb;
    end
  end

  always @(negedge clk) begin
    if (!resetn) exp_rpc <= 32'h100;
    if (mready) begin
      chk("valid", 64'(valid), 64'(mv));
      chk("allow_in", 64'(allow_in), 64'(m_allow()));
      for (int j = 1; j < S; j++)
        chk($sformatf("bus%0d", j), 64'(sbr[(j-1)*BW +: BW]),
            64'(mb[j]));
      chk("retire_cnt", 64'(retire_cnt), 64'(mret));
      chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
      if (resetn && rtrack && valid[S-1] && stage_over[S-1]) begin
        chk("retire_pc", 64'(sbr[(S-2)*BW +: PW]), 64'(exp_rpc));
        exp_rpc <= exp_rpc + 32'd4;
      end
    end
  end

  function automatic bit hi_or();
    bit r;
    r = 1'b0;
    for (int j = 0; j < S - 1; j++)
      r = r | (|sbr[j*BW+PW +: BW-PW]);
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; stage_over = '0; cancel = 1'b0;
    flush_req = 1'b0; flush_idx = '0; rtrack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_bus", 64'(|sbr), 64'h0);
    chk("rst_retire", 64'(retire_cnt), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);

    @(posedge clk); #1; resetn = 1'b1; stage_over = '1;
    @(posedge clk); @(negedge clk);
    chk("rel_valid", 64'(valid), 64'h01);
    repeat (4) @(posedge clk); @(negedge clk);
    chk("stream_pc", 64'(sbr[3*BW +: BW]), 64'hA5A5_0000_0100);
    chk("stream_valid", 64'(valid), 64'h1F);
    repeat (3) @(posedge clk); @(negedge clk);
    chk("stream_ret", 64'(retire_cnt), 64'd3);

    @(posedge clk); #1; stage_over = 5'b01111;
    @(negedge clk);
    chk("bp_allow", 64'(allow_in), 64'h0);
    repeat (3) @(posedge clk); #1; stage_over = '1;
    @(negedge clk);
    chk("bp_stall", 64'(stall_cnt), 64'd3);
    chk("bp_retire", 64'(retire_cnt), 64'd4);
    chk("bp_hold_pc", 64'(sbr[3*BW +: PW]), 64'h110);

    repeat (4) @(posedge clk); #1; rtrack = 1'b0; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_valid", 64'(valid), 64'h01);
    chk("cancel_hi", 64'(hi_or()), 64'h0);
    chk("cancel_retire", 64'(retire_cnt), 64'd9);

    repeat (5) @(posedge clk); #1;
    stage_over = 5'b11011; flush_req = 1'b1; flush_idx = 3'd2;
    @(negedge clk);
    chk("fl_allow", 64'(allow_in), 64'h19);
    @(posedge clk); #1; stage_over = '1;
    @(negedge clk);
    chk("fl_hold_valid", 64'(valid), 64'h15);
    @(posedge clk); #1; flush_req = 1'b0;
    @(negedge clk);
    chk("fl_adv_valid", 64'(valid), 64'h09);
    chk("fl_bus2_hi", 64'(sbr[BW+PW +: BW-PW]), 64'h0);

    repeat (5) @(posedge clk); #1;
    stage_over = 5'b11011; flush_req = 1'b1; flush_idx = 3'd7;
    @(posedge clk); #1; stage_over = '1; flush_req = 1'b0;
    @(negedge clk);
    chk("oor_valid", 64'(valid), 64'h17);

    repeat (3) @(posedge clk); #1;
    cancel = 1'b1; flush_req = 1'b1; flush_idx = 3'd3;
    @(posedge clk); #1; cancel = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    chk("cf_valid", 64'(valid), 64'h01);
    chk("cf_bus4_hi", 64'(sbr[3*BW+PW +: BW-PW]), 64'h0);

    repeat (5) @(posedge clk); #1; resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(valid), 64'h0);
    chk("mid_rst_bus", 64'(|sbr), 64'h0);
    chk("mid_rst_retire", 64'(retire_cnt), 64'h0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'h0);
    @(posedge clk); #1; resetn = 1'b1; rtrack = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel2_valid", 64'(valid), 64'h01);
    repeat (4) @(posedge clk); @(negedge clk);
    chk("fill_retire", 64'(retire_cnt), 64'd0);
    chk("fill_valid", 64'(valid), 64'h1F);
    repeat (17) @(posedge clk); @(negedge clk);
    chk("wrap_retire", 64'(retire_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
